// File: rtl/wam_pkg.sv
// Shared types and constants for the whack-a-mole mole scheduler.
package wam_pkg;

  localparam int unsigned NUM_HOLES = 9;
  localparam int unsigned HOLE_W    = 4;
  localparam logic [HOLE_W-1:0] MAX_HOLE = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_CHECK = 3'd2,
    ST_SHOW  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  // Registered output bundle toward the generator and score/display logic
  typedef struct packed {
    logic [NUM_HOLES-1:0] mole;
    logic                 rnd_req;
    logic                 score;
    logic                 miss;
    logic                 wrong;
  } sched_out_t;

  // One-hot hole mask; out-of-range indices give an empty mask
  function automatic logic [NUM_HOLES-1:0] hole_mask(input logic [HOLE_W-1:0] hole);
    logic [NUM_HOLES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_HOLES; i++) begin
      if (hole == HOLE_W'(i)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/tick_downcounter.sv
// Tick-driven down-counter; done_c flags a tick seen while the count is 1.
module tick_downcounter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             done_c
);

  logic [CNT_W-1:0] count;

  // Load wins over a coincident tick; the count parks at zero
  always_ff @(posedge clk) begin
    if (!reset)                    count <= '0;
    else if (load)                 count <= load_val;
    else if (tick && count != '0)  count <= count - CNT_W'(1);
  end

  assign done_c = tick && !load && (count == CNT_W'(1));

endmodule

// File: rtl/mole_scheduler.sv
// Mole scheduler: requests hole indices, shows one mole, judges hits.
// Optional SPEEDUP_EN shortens the mole lifetime after each successful hit.
module mole_scheduler
  import wam_pkg::*;
#(
  parameter int unsigned LIFE_TICKS = 50,
  parameter int unsigned GAP_TICKS  = 20,
  parameter int unsigned MIN_LIFE   = 10,
  parameter int unsigned LIFE_STEP  = 5,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 tick,
  input  logic                 rnd_valid,
  input  logic [HOLE_W-1:0]    rnd_num,
  input  logic [NUM_HOLES-1:0] hit,
  output logic                 rnd_req,
  output logic [NUM_HOLES-1:0] mole,
  output logic                 score_pulse,
  output logic                 miss_pulse,
  output logic                 wrong_pulse
);

  // All tick parameters must fit the counter width
  if (LIFE_TICKS >= (1 << CNT_W) || GAP_TICKS >= (1 << CNT_W) ||
      MIN_LIFE >= (1 << CNT_W) || LIFE_STEP >= (1 << CNT_W)) begin : g_param_check
    $error("mole_scheduler: tick parameter does not fit CNT_W");
  end

  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_TICKS);
  localparam logic             NO_GAP   = (GAP_TICKS == 0);

  state_e               state, state_nxt;
  sched_out_t           out_q, out_d;
  logic [HOLE_W-1:0]    hole;
  logic [CNT_W-1:0]     life_cur;
  logic [NUM_HOLES-1:0] hole_mask_c;
  logic                 xfer_c, hit_ok_c, hit_bad_c;
  logic                 life_load_c, gap_load_c, life_done_c, gap_done_c;

  assign hole_mask_c = hole_mask(hole);
  assign xfer_c      = out_q.rnd_req && rnd_valid;
  assign hit_ok_c    = |(hit & hole_mask_c);
  assign hit_bad_c   = |(hit & ~hole_mask_c);

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_REQ;
        ST_REQ:   if (xfer_c) state_nxt = ST_CHECK;
        ST_CHECK: state_nxt = (hole <= MAX_HOLE) ? ST_SHOW : ST_REQ;
        ST_SHOW:  if (hit_ok_c || life_done_c) state_nxt = ST_GAP;
        ST_GAP:   if (NO_GAP || gap_done_c) state_nxt = ST_REQ;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs plus counter load strobes
  always_comb begin
    out_d       = '0;
    life_load_c = 1'b0;
    gap_load_c  = 1'b0;
    if (enable) begin
      out_d.rnd_req = (state_nxt == ST_REQ);
      case (state)
        ST_CHECK: begin
          if (state_nxt == ST_SHOW) begin
            out_d.mole  = hole_mask_c;
            life_load_c = 1'b1;
          end
        end
        ST_SHOW: begin
          out_d.score = hit_ok_c;
          out_d.wrong = hit_bad_c;
          out_d.miss  = life_done_c && !hit_ok_c;
          out_d.mole  = (state_nxt == ST_SHOW) ? hole_mask_c : '0;
          gap_load_c  = (state_nxt == ST_GAP);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) out_q <= '0;
    else        out_q <= out_d;
  end

  always_ff @(posedge clk) begin
    if (!reset)                                     hole <= '0;
    else if (enable && state == ST_REQ && xfer_c)  hole <= rnd_num;
  end

`ifdef SPEEDUP_EN
  localparam logic [CNT_W-1:0] LIFE_FLOOR = CNT_W'(MIN_LIFE);
  localparam logic [CNT_W-1:0] LIFE_DEC   = CNT_W'(LIFE_STEP);

  // Saturating lifetime shrink on every successful hit
  always_ff @(posedge clk) begin
    if (!reset) begin
      life_cur <= CNT_W'(LIFE_TICKS);
    end else if (out_d.score) begin
      life_cur <= (life_cur > LIFE_DEC && (life_cur - LIFE_DEC) > LIFE_FLOOR)
                  ? life_cur - LIFE_DEC : LIFE_FLOOR;
    end
  end
`else
  assign life_cur = CNT_W'(LIFE_TICKS);
`endif

  tick_downcounter #(.CNT_W(CNT_W)) u_life_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (life_load_c),
    .load_val (life_cur),
    .tick     (tick),
    .done_c   (life_done_c)
  );

  tick_downcounter #(.CNT_W(CNT_W)) u_gap_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load_c),
    .load_val (GAP_LOAD),
    .tick     (tick),
    .done_c   (gap_done_c)
  );

  assign rnd_req     = out_q.rnd_req;
  assign mole        = out_q.mole;
  assign score_pulse = out_q.score;
  assign miss_pulse  = out_q.miss;
  assign wrong_pulse = out_q.wrong;

endmodule

// File: tb/tb_mole_scheduler.sv
// Scoreboard bench for mole_scheduler; SPEEDUP_EN selects the speed-up scenario.
module tb_mole_scheduler;

`ifdef SPEEDUP_EN
  localparam int LIFE = 20;
`else
  localparam int LIFE = 4;
`endif
  localparam int GAP   = 2;
  localparam int MINL  = 10;
  localparam int STEP  = 5;

  logic       clk = 1'b0;
  logic       reset, enable, tick, rnd_valid;
  logic [3:0] rnd_num;
  logic [8:0] hit;
  logic       rnd_req, score_pulse, miss_pulse, wrong_pulse;
  logic [8:0] mole;

  int n_checks = 0;
  int n_errors = 0;
  int life_m   = LIFE;

  logic [11:0] exp_q[$];
  logic [11:0] snap;
  logic [11:0] prev_snap = '0;

  mole_scheduler #(
    .LIFE_TICKS(LIFE), .GAP_TICKS(GAP), .MIN_LIFE(MINL), .LIFE_STEP(STEP), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .tick(tick),
    .rnd_valid(rnd_valid), .rnd_num(rnd_num), .hit(hit),
    .rnd_req(rnd_req), .mole(mole), .score_pulse(score_pulse),
    .miss_pulse(miss_pulse), .wrong_pulse(wrong_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: every change of {mole, score, miss, wrong} must match the next expected entry
  assign snap = {mole, score_pulse, miss_pulse, wrong_pulse};
  always @(negedge clk) begin
    if (snap !== prev_snap) begin
      if (exp_q.size() == 0) check("sb_unexpected", 32'(snap), 32'(prev_snap));
      else                   check("sb_event", 32'(snap), 32'(exp_q.pop_front()));
      prev_snap <= snap;
    end
  end

  task automatic expect_ev(input logic [8:0] m, input logic s, input logic mi, input logic w);
    exp_q.push_back({m, s, mi, w});
  endtask

  task automatic cyc1(input logic t, input logic [8:0] h);
    tick = t;
    hit  = h;
    @(negedge clk);
    tick = 1'b0;
    hit  = '0;
  endtask

  task automatic give(input logic [3:0] n);
    int w;
    w = 0;
    while (!rnd_req && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("give_req", rnd_req, 1'b1);
    rnd_valid = 1'b1;
    rnd_num   = n;
    @(negedge clk);
    rnd_valid = 1'b0;
  endtask

  task automatic gap_wait();
    cyc1(1'b0, 9'h1ff);
    check("gap_ignore_hit", {score_pulse, miss_pulse, wrong_pulse}, 3'b000);
    for (int g = 0; g < GAP; g++) begin
      check("gap_req_low", rnd_req, 1'b0);
      cyc1(1'b0, '0);
      cyc1(1'b1, '0);
    end
    check("gap_to_req", rnd_req, 1'b1);
  endtask

  task automatic scored();
`ifdef SPEEDUP_EN
    life_m = (life_m - STEP > MINL) ? life_m - STEP : MINL;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; enable = 1'b1; tick = 1'b0; rnd_valid = 1'b0; rnd_num = '0; hit = '0;

    repeat (3) @(negedge clk);
    check("rst_outputs", {rnd_req, mole, score_pulse, miss_pulse, wrong_pulse}, 13'h0);
    reset = 1'b1;
    @(negedge clk);
    check("req_after_rst", rnd_req, 1'b1);

    // Out-of-range index is rejected, then hole 3 is shown
    give(4'd12);
    check("xfer_req_low", rnd_req, 1'b0);
    @(negedge clk);
    check("re_req", {rnd_req, mole}, {1'b1, 9'h000});
    expect_ev(9'h008, 1'b0, 1'b0, 1'b0);
    give(4'd3);
    check("mole_lat1", mole, 9'h000);
    @(negedge clk);
    check("mole_h3", {rnd_req, mole}, {1'b0, 9'h008});

    // Expiry with a tick every 10 cycles
    expect_ev(9'h000, 1'b0, 1'b1, 1'b0);
    expect_ev(9'h000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < LIFE; i++) begin
      repeat (9) cyc1(1'b0, '0);
      cyc1(1'b1, '0);
      if (i < LIFE - 1) check("alive", {mole, miss_pulse}, {9'h008, 1'b0});
      else              check("expire", {mole, miss_pulse}, {9'h000, 1'b1});
    end
    gap_wait();

    // Correct hit coincident with the expiring tick
    expect_ev(9'h020, 1'b0, 1'b0, 1'b0);
    give(4'd5);
    @(negedge clk);
    check("mole_h5", mole, 9'h020);
    expect_ev(9'h000, 1'b1, 1'b0, 1'b0);
    expect_ev(9'h000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < LIFE - 1; i++) cyc1(1'b1, '0);
    cyc1(1'b1, 9'h020);
    check("hit_on_expire", {score_pulse, miss_pulse, mole}, {1'b1, 1'b0, 9'h000});
    scored();
    gap_wait();

    // Wrong holes, then correct and wrong together
    expect_ev(9'h020, 1'b0, 1'b0, 1'b0);
    give(4'd5);
    @(negedge clk);
    expect_ev(9'h020, 1'b0, 1'b0, 1'b1);
    expect_ev(9'h020, 1'b0, 1'b0, 1'b0);
    cyc1(1'b0, 9'h003);
    check("wrong", {wrong_pulse, score_pulse, mole}, {1'b1, 1'b0, 9'h020});
    cyc1(1'b0, '0);
    check("wrong_once", {wrong_pulse, mole}, {1'b0, 9'h020});
    expect_ev(9'h000, 1'b1, 1'b0, 1'b1);
    expect_ev(9'h000, 1'b0, 1'b0, 1'b0);
    cyc1(1'b0, 9'h021);
    check("score_and_wrong", {score_pulse, wrong_pulse, mole}, {1'b1, 1'b1, 9'h000});
    scored();
    gap_wait();

    // Third hit, then measure the following mole's lifetime
    expect_ev(9'h080, 1'b0, 1'b0, 1'b0);
    expect_ev(9'h000, 1'b1, 1'b0, 1'b0);
    expect_ev(9'h000, 1'b0, 1'b0, 1'b0);
    give(4'd7);
    @(negedge clk);
    cyc1(1'b0, 9'h080);
    check("score_h7", score_pulse, 1'b1);
    scored();
    gap_wait();
    expect_ev(9'h001, 1'b0, 1'b0, 1'b0);
    expect_ev(9'h000, 1'b0, 1'b1, 1'b0);
    expect_ev(9'h000, 1'b0, 1'b0, 1'b0);
    give(4'd0);
    @(negedge clk);
    n = 0;
    do begin
      cyc1(1'b1, '0);
      n++;
    end while (!miss_pulse && n < 64);
    check("life_len", 32'(n), 32'(life_m));
    gap_wait();

    // Disable mid-SHOW; stray rnd_valid and hits while idle are ignored
    expect_ev(9'h010, 1'b0, 1'b0, 1'b0);
    expect_ev(9'h000, 1'b0, 1'b0, 1'b0);
    give(4'd4);
    @(negedge clk);
    check("mole_h4", mole, 9'h010);
    enable = 1'b0;
    cyc1(1'b0, '0);
    check("dis_mole", {mole, rnd_req}, 10'h0);
    rnd_valid = 1'b1;
    rnd_num   = 4'd2;
    repeat (3) cyc1(1'b0, 9'h1ff);
    check("dis_idle", {rnd_req, score_pulse, miss_pulse, wrong_pulse, mole}, 13'h0);
    rnd_valid = 1'b0;
    enable    = 1'b1;
    cyc1(1'b0, '0);
    check("reen_req", {rnd_req, mole}, {1'b1, 9'h000});
    repeat (3) @(negedge clk);
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
- Consumer end of the random-number generator interface in the whack-a-mole game.
- Requests hole indices with a req/valid handshake and rejects out-of-range values (9..15).
- Raises one mole at a time on a one-hot 9-hole mask, times its lifetime in game ticks, and judges the hit buttons.
- Emits score, miss and wrong-hole pulses to the score/display logic.

Parameters:
LIFE_TICKS, 50, ticks a mole stays up (reset value of current lifetime)
GAP_TICKS, 20, ticks between a mole retiring and the next request; 0 = no gap
MIN_LIFE, 10, lower bound of lifetime under SPEEDUP_EN
LIFE_STEP, 5, lifetime reduction per successful hit under SPEEDUP_EN
CNT_W, 8, width of tick counters; all tick parameters < 2**CNT_W

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
enable  in  1  game running; low forces IDLE
tick  in  1  one-cycle timebase strobe
rnd_valid  in  1  generator has a number on rnd_num
rnd_num  in  4  candidate hole index
hit  in  9  debounced one-cycle button pulses, bit i = hole i
rnd_req  out  1  registered request to generator
mole  out  9  one-hot active-hole mask, registered
score_pulse  out  1  one cycle, correct hole hit
miss_pulse  out  1  one cycle, mole expired unhit
wrong_pulse  out  1  one cycle, a non-active hole was hit while a mole was up

Behaviour:
- Reset (reset==0 at posedge): state IDLE; all outputs 0; hole register 0; life_cur = LIFE_TICKS. Mid-operation reset discards the pending request and the mole.
- States: IDLE, REQ, CHECK, SHOW, GAP.
- enable==0 at any posedge: next state IDLE, mole=0, rnd_req=0, no pulses. life_cur is kept.
- IDLE: if enable, go to REQ next cycle.
- REQ: rnd_req=1 while in REQ. Transfer occurs on a cycle with rnd_req && rnd_valid: rnd_num is latched into the hole register, and the next state is CHECK. rnd_req is therefore low the cycle after the transfer. rnd_valid without rnd_req is ignored.
- CHECK (1 cycle):
  - hole <= 8: go to SHOW; mole <= 1<<hole; life counter <= life_cur.
  - hole > 8: return to REQ (re-request). No limit on retries.
- SHOW:
  - Each tick decrements the life counter.
  - A tick seen with counter==1 expires the mole: miss_pulse=1, mole=0, enter GAP.
  - hit[hole]: score_pulse=1, mole=0, enter GAP.
  - Any other hit bit set: wrong_pulse=1 (once per cycle, regardless of how many bits); the mole stays.
  - Correct and wrong bits in the same cycle: both pulses fire.
  - Hit and expiry in the same cycle: the hit wins (score_pulse, no miss_pulse).
- GAP: load gap counter with GAP_TICKS on entry; each tick decrements it; tick at counter==1 moves to REQ. With GAP_TICKS==0, move from GAP to REQ on the next cycle without waiting for a tick.
- Hits outside SHOW are ignored (no pulses).
- Pulses are registered and appear the cycle after the causing edge. mole changes on the same edge as the state.
- Minimum latency: rnd_valid to mole visible is 2 cycles (REQ to CHECK to SHOW).

Optional Feature:
SPEEDUP_EN
- Defined: each score_pulse sets life_cur <= max(MIN_LIFE, life_cur - LIFE_STEP), saturating with no underflow. life_cur is restored to LIFE_TICKS only by reset.
- Undefined: life_cur is constant LIFE_TICKS; MIN_LIFE and LIFE_STEP are unused.

Decomposition:
- Package wam_pkg: state enumeration, NUM_HOLES=9, HOLE_W=4, MAX_HOLE=4'd8.
- Sub-module tick_downcounter (load, load_val, tick, done when a tick is seen at count 1), instantiated twice: once for life, once for gap.

Test Plan:
- Reset held 3 cycles with enable=1 -> all outputs 0. After release, rnd_req=1 one cycle later.
- Provide rnd_num=12, then rnd_num=3 -> after 12: CHECK, then rnd_req re-asserted, no mole. After 3: mole=9'b000001000 two cycles after the transfer.
- LIFE_TICKS=4, no hits, tick every 10 cycles -> miss_pulse one cycle after the 4th tick, mole cleared. With GAP_TICKS=2, rnd_req rises after 2 more ticks.
- Mole at hole 5: hit=9'b000100000 coincident with the expiring tick -> score_pulse=1, miss_pulse=0.
- Mole at hole 5: hit=9'b000000011 -> wrong_pulse=1 for exactly one cycle, mole unchanged.
- SPEEDUP_EN with LIFE_TICKS=20, LIFE_STEP=5, MIN_LIFE=10 -> successive hits give life_cur of 15, then 10, then 10. Deassert enable mid-SHOW -> mole=0 next cycle, state IDLE.
